// File: rtl/dl_instr_encoder.sv
// rtl/dl_instr_encoder.sv - FP operation to 32-bit instruction encoder with 2-entry output FIFO
// Optional FMA/FMS encoding enabled by defining DL_FMA_EN.
module dl_instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rs3,
  input  logic [2:0]  req_rm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        illegal,
  output logic [15:0] issue_cnt
);

  localparam logic [6:0] OPC_FP  = 7'b1011011;
  localparam logic [6:0] OPC_FMA = 7'b1000011;
  localparam logic [6:0] OPC_FMS = 7'b1000111;

  logic [4:0]  f5;
  logic [4:0]  rs2_f;
  logic [2:0]  rm_f;
  logic [6:0]  opc;
  logic        legal;
  logic [31:0] word;

  always_comb begin
    f5    = 5'b00000;
    rs2_f = req_rs2;
    rm_f  = req_rm;
    opc   = OPC_FP;
    legal = 1'b1;
    case (req_op)
      5'd0:  f5 = 5'b00000;
      5'd1:  f5 = 5'b00001;
      5'd2:  f5 = 5'b00010;
      5'd3:  f5 = 5'b00011;
      5'd4:  begin f5 = 5'b01011; rs2_f = 5'd0; end
      5'd5:  begin f5 = 5'b00100; rm_f = 3'b000; end
      5'd6:  begin f5 = 5'b00100; rm_f = 3'b001; end
      5'd7:  begin f5 = 5'b00100; rm_f = 3'b010; end
      5'd8:  begin f5 = 5'b00101; rm_f = 3'b000; end
      5'd9:  begin f5 = 5'b00101; rm_f = 3'b001; end
      5'd10: begin f5 = 5'b01000; rs2_f = 5'd0; end
      5'd11: begin f5 = 5'b01001; rs2_f = 5'd0; end
      5'd12: begin f5 = 5'b10100; rm_f = 3'b010; end
      5'd13: begin f5 = 5'b10100; rm_f = 3'b001; end
      5'd14: begin f5 = 5'b10100; rm_f = 3'b000; end
      5'd15, 5'd16: begin
        // rs3 occupies the funct5 slot for the fused ops
        f5  = req_rs3;
        opc = (req_op == 5'd15) ? OPC_FMA : OPC_FMS;
`ifdef DL_FMA_EN
        legal = 1'b1;
`else
        legal = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase
    word = {f5, 2'b10, rs2_f, req_rs1, rm_f, req_rd, opc};
  end

  logic [1:0]  count;
  logic [31:0] head;
  logic [31:0] tail;
  logic        accept;
  logic        push;
  logic        pop;

  assign req_ready   = (count != 2'd2);
  assign accept      = req_valid && req_ready;
  assign push        = accept && legal;
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  // head is kept zero whenever the FIFO is empty, so it can drive instr directly
  assign instr       = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head      <= 32'h0;
      tail      <= 32'h0;
      illegal   <= 1'b0;
      issue_cnt <= 16'h0;
    end else begin
      illegal <= accept && !legal;
      if (pop) issue_cnt <= issue_cnt + 16'd1;
      case (count)
        2'd0: begin
          if (push) begin
            head  <= word;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= word;
          end else if (push) begin
            tail  <= word;
            count <= 2'd2;
          end else if (pop) begin
            head  <= 32'h0;
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head <= tail;
            if (push) begin
              tail <= word;
            end else begin
              tail  <= 32'h0;
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dl_instr_encoder.sv
// tb/tb_dl_instr_encoder.sv - randomized check of dl_instr_encoder against a queue-based reference model
module tb_dl_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rs3;
  logic [2:0]  req_rm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        illegal;
  logic [15:0] issue_cnt;

  dl_instr_encoder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs3(req_rs3), .req_rm(req_rm), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .illegal(illegal), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt;
  logic        exp_ill;

  // funct5 per op 0..14; rm_tab = -1 means the request's rm is used
  int f5_tab[15] = '{0, 1, 2, 3, 11, 4, 4, 4, 5, 5, 8, 9, 20, 20, 20};
  int rm_tab[15] = '{-1, -1, -1, -1, -1, 0, 1, 2, 0, 1, -1, -1, 2, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_legal(input int op);
`ifdef DL_FMA_EN
    return op <= 16;
`else
    return op <= 14;
`endif
  endfunction

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input int rs3, input int rm);
    int top, rmf, r2, opc;
    if (op >= 15) begin
      top = rs3; rmf = rm; r2 = rs2;
      opc = (op == 15) ? 'h43 : 'h47;
    end else begin
      top = f5_tab[op];
      rmf = (rm_tab[op] < 0) ? rm : rm_tab[op];
      r2  = (op == 4 || op == 10 || op == 11) ? 0 : rs2;
      opc = 'h5B;
    end
    return 32'(top * (1 << 27) + 2 * (1 << 25) + r2 * (1 << 20) + rs1 * (1 << 15)
               + rmf * (1 << 12) + rd * (1 << 7) + opc);
  endfunction

  // Compare outputs, apply one cycle of inputs, advance model, step to next negedge.
  task automatic cyc(input bit r, input bit v, input int op, input int rd, input int rs1,
                     input int rs2, input int rs3, input int rm, input bit ir);
    bit acc, pp;
    check("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
    check("instr", instr, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
    check("req_ready", 32'(req_ready), 32'(exp_q.size() < 2));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("issue_cnt", 32'(issue_cnt), 32'(exp_cnt));
    rst = r; req_valid = v; req_op = 5'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1);
    req_rs2 = 5'(rs2); req_rs3 = 5'(rs3); req_rm = 3'(rm); instr_ready = ir;
    if (r) begin
      exp_q.delete();
      exp_cnt = 16'h0;
      exp_ill = 1'b0;
    end else begin
      acc = v && (exp_q.size() < 2);
      pp  = (exp_q.size() > 0) && ir;
      if (pp) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      exp_ill = acc && !ref_legal(op);
      if (acc && ref_legal(op)) exp_q.push_back(ref_word(op, rd, rs1, rs2, rs3, rm));
    end
    @(negedge clk);
  endtask

  initial begin
    exp_cnt = 16'h0;
    exp_ill = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0;
    req_rs2 = '0; req_rs3 = '0; req_rm = '0; instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // directed vectors: ADD, FLE, SQRT, illegal op, FMA
    cyc(0, 1, 0, 3, 1, 2, 0, 0, 1);
    check("add_word", instr, 32'h042081DB);
    cyc(0, 1, 14, 5, 6, 7, 0, 3, 1);
    check("fle_word", instr, 32'hA47302DB);
    cyc(0, 1, 4, 1, 2, 9, 0, 0, 1);
    check("sqrt_word", instr, 32'h5C0100DB);
    cyc(0, 1, 20, 1, 1, 1, 1, 0, 1);
    check("illegal_pulse", 32'(illegal), 32'd1);
    cyc(0, 1, 15, 1, 2, 3, 4, 0, 1);
`ifdef DL_FMA_EN
    check("fma_word", instr, 32'h243100C3);
`else
    check("fma_disabled", 32'(illegal), 32'd1);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // backpressure: three requests with consumer stalled, then release
    cyc(0, 1, 1, 1, 2, 3, 0, 1, 0);
    cyc(0, 1, 2, 4, 5, 6, 0, 2, 0);
    cyc(0, 1, 3, 7, 8, 9, 0, 3, 0);
    check("full_ready", 32'(req_ready), 32'd0);
    cyc(0, 1, 3, 7, 8, 9, 0, 3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // fill, then reset mid-operation with a same-cycle request
    cyc(0, 1, 5, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 6, 2, 2, 2, 0, 0, 0);
    cyc(1, 1, 7, 3, 3, 3, 0, 0, 1);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 200) == 0, $urandom % 4 != 0, int'($urandom % 24),
          int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
          int'($urandom % 32), int'($urandom % 8), $urandom % 3 != 0);
    end

    // counter wrap: one handshake per cycle until issue_cnt passes 16'hFFFF
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      cyc(0, 1, 0, i % 32, 1, 2, 0, 0, 1);
    end
    check("cnt_wrapped", 32'(issue_cnt), 32'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
